// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control stage of the 8-entry FIFO. Holds state/head/tail/count,
// closes the pointer loop with the address calculator, decodes status flags.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   wr_en, rd_en               user requests, sampled at rising clk
//   next_head, next_tail       calculator results, registered every edge
//   next_data_count            calculator occupancy after the current op
//   state, head, tail          registered state/pointers to calculator
//   data_count                 registered occupancy 0..8
//   full, empty                occupancy decodes
//   wr_ack, wr_err             write accepted / refused strobes
//   rd_ack, rd_err             read accepted / refused strobes
module fifo_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [2:0] next_head,
    input  logic [2:0] next_tail,
    input  logic [3:0] next_data_count,
    output logic [2:0] state,
    output logic [2:0] head,
    output logic [2:0] tail,
    output logic [3:0] data_count,
    output logic       full,
    output logic       empty,
    output logic       wr_ack,
    output logic       wr_err,
    output logic       rd_ack,
    output logic       rd_err
);

    // Encoding is shared with the address calculator.
    typedef enum logic [2:0] {
        INIT   = 3'b000,
        WRITE  = 3'b001,
        WR_ERR = 3'b010,
        NO_OP  = 3'b011,
        READ   = 3'b100,
        RD_ERR = 3'b101
    } state_t;

    state_t     cs;
    state_t     ns;
    logic [2:0] head_q;
    logic [2:0] tail_q;
    logic [3:0] cnt_q;

    // Decisions use next_data_count so a request sees the occupancy
    // including the operation currently in flight. The current state does
    // not enter the decision, so stray encodings recover on the next edge.
    always_comb begin
        ns = NO_OP;
        case (1'b1)
            wr_en && !rd_en:
                ns = (next_data_count == 4'd8) ? WR_ERR : WRITE;
            rd_en && !wr_en:
                ns = (next_data_count == 4'd0) ? RD_ERR : READ;
            default:
                ns = NO_OP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs     <= INIT;
            head_q <= 3'd0;
            tail_q <= 3'd0;
            cnt_q  <= 4'd0;
        end else begin
            cs     <= ns;
            head_q <= next_head;
            tail_q <= next_tail;
            cnt_q  <= next_data_count;
        end
    end

    assign state      = cs;
    assign head       = head_q;
    assign tail       = tail_q;
    assign data_count = cnt_q;

    // Pure decodes of registers: no path from wr_en/rd_en to outputs.
    assign full   = (cnt_q == 4'd8);
    assign empty  = (cnt_q == 4'd0);
    assign wr_ack = (cs == WRITE);
    assign wr_err = (cs == WR_ERR);
    assign rd_ack = (cs == READ);
    assign rd_err = (cs == RD_ERR);

endmodule
